// File: rtl/edge_pkg.sv
// Shared constants and types for the Sobel edge-detection datapath.
package edge_pkg;

    localparam int IMG_WIDTH  = 352;
    localparam int IMG_HEIGHT = 288;
    localparam int BASE_ADDR  = 0;
    localparam int WPR        = IMG_WIDTH / 4;
    localparam int RESULT_W   = 10;

    typedef logic [7:0]          pixel_t;
    typedef logic [31:0]         word_t;
    typedef logic [15:0]         addr_t;
    typedef logic [RESULT_W-1:0] result_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_F3,
        S_EMIT,
        S_DONE
    } feeder_state_t;

    // Pixel 0 is the leftmost pixel and sits in the least significant byte.
    function automatic pixel_t get_pixel(word_t word, logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sobel_column_feeder.sv
// Fetches rows y-1, y, y+1 one word column at a time and streams vertical
// pixel triplets to the a + 2b + c ALU over a valid/ready handshake.
module sobel_column_feeder #(
    parameter int IMG_WIDTH  = edge_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = edge_pkg::IMG_HEIGHT,
    parameter int BASE_ADDR  = edge_pkg::BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  row,
    output logic        busy,
    output logic        done,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_data_r,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [7:0]  c,
    output logic [8:0]  col_index,
    output logic        col_valid,
    input  logic        col_ready
);
    import edge_pkg::*;

    // col_index is 9 bits wide, so the word column always fits in 7 bits.
    localparam int            ROW_WORDS  = IMG_WIDTH / 4;
    localparam int            WW         = 7;
    localparam logic [WW-1:0] LAST_W     = WW'(ROW_WORDS - 1);
    localparam addr_t         ROW_STRIDE = addr_t'(ROW_WORDS);
    localparam logic [8:0]    MAX_ROW    = 9'(IMG_HEIGHT - 2);

    feeder_state_t state;
    logic [WW-1:0] w;
    logic [1:0]    k;
    logic [1:0]    k_next;
    word_t         above_w;
    word_t         center_w;
    word_t         below_w;
    addr_t         word_addr;
    addr_t         start_addr;
    logic          row_ok;

    // The only multiply: top-row base address, taken once when a row starts.
    assign start_addr = addr_t'(BASE_ADDR) + addr_t'(row - 9'd1) * ROW_STRIDE;
    assign row_ok     = (row >= 9'd1) && (row <= MAX_ROW);
    assign k_next     = 2'(k + 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            w         <= '0;
            k         <= '0;
            above_w   <= '0;
            center_w  <= '0;
            below_w   <= '0;
            word_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            col_index <= '0;
            col_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (row_ok) begin
                            state     <= S_F0;
                            w         <= '0;
                            k         <= '0;
                            word_addr <= start_addr;
                            mem_addr  <= start_addr;
                            mem_en    <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_F0: begin
                    state    <= S_F1;
                    mem_addr <= mem_addr + ROW_STRIDE;
                end
                S_F1: begin
                    above_w  <= mem_data_r;
                    state    <= S_F2;
                    mem_addr <= mem_addr + ROW_STRIDE;
                end
                S_F2: begin
                    center_w <= mem_data_r;
                    state    <= S_F3;
                    mem_en   <= 1'b0;
                end
                S_F3: begin
                    below_w   <= mem_data_r;
                    state     <= S_EMIT;
                    k         <= '0;
                    col_valid <= 1'b1;
                    a         <= get_pixel(above_w, 2'd0);
                    b         <= get_pixel(center_w, 2'd0);
                    c         <= get_pixel(mem_data_r, 2'd0);
                    col_index <= {w, 2'b00};
                end
                S_EMIT: begin
                    if (col_ready) begin
                        if (k != 2'd3) begin
                            k         <= k_next;
                            a         <= get_pixel(above_w, k_next);
                            b         <= get_pixel(center_w, k_next);
                            c         <= get_pixel(below_w, k_next);
                            col_index <= col_index + 9'd1;
                        end else begin
                            col_valid <= 1'b0;
                            if (w != LAST_W) begin
                                w         <= w + 1'b1;
                                word_addr <= word_addr + 16'd1;
                                mem_addr  <= word_addr + 16'd1;
                                mem_en    <= 1'b1;
                                state     <= S_F0;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_column_feeder.sv
// Randomized self-checking bench: a pixel-level row model predicts every
// fetch address and column triplet the feeder should produce.
`timescale 1ns/1ps
module tb_sobel_column_feeder;

    localparam int WPR       = 88;
    localparam int WIDTH     = 352;
    localparam int MEM_WORDS = 25344;
    localparam int BUDGET    = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  row = '0;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_data_r = '0;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [8:0]  col_index;
    logic        col_valid;
    logic        col_ready = 1'b1;

    logic [31:0] mem [0:MEM_WORDS-1];
    int checks = 0;
    int failures = 0;
    logic [23:0] first_abc;

    sobel_column_feeder dut (
        .clk(clk), .rst(rst), .start(start), .row(row),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data_r(mem_data_r), .a(a), .b(b), .c(c),
        .col_index(col_index), .col_valid(col_valid), .col_ready(col_ready)
    );

    always #5 clk = ~clk;

    // Pixel memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en)
            mem_data_r <= (int'(mem_addr) < MEM_WORDS) ? mem[mem_addr] : 32'h0;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start_v, input logic [8:0] row_v);
        start = start_v;
        row   = row_v;
    endtask

    function automatic logic [7:0] pix(input int addr, input int k);
        logic [31:0] word;
        word = mem[addr];
        return 8'((word >> (8 * k)) & 32'hFF);
    endfunction

    // mode 0: ready always high; 1: random ready; 2: ready dropped 3 cycles at column 1
    task automatic runRow(input int y, input int mode, input bit pulse_start);
        int addrq[$];
        logic [32:0] tripq[$];
        int n, done_at, first_valid, first_en, reads, transfers, last_addr;
        int exp_reads, exp_trans, drop_left;
        bit valid_row, dropped;
        logic [32:0] obs;

        valid_row = (y >= 1) && (y <= 286);
        if (valid_row) begin
            for (int wc = 0; wc < WPR; wc++) begin
                addrq.push_back((y - 1) * WPR + wc);
                addrq.push_back(y * WPR + wc);
                addrq.push_back((y + 1) * WPR + wc);
            end
            for (int x = 0; x < WIDTH; x++)
                tripq.push_back({pix((y - 1) * WPR + x / 4, x % 4),
                                 pix(y * WPR + x / 4, x % 4),
                                 pix((y + 1) * WPR + x / 4, x % 4),
                                 9'(x)});
        end
        exp_reads = addrq.size();
        exp_trans = tripq.size();

        applyStimulus(1'b1, 9'(y));
        col_ready = 1'b1;
        tick();
        applyStimulus(1'b0, 9'(y));

        done_at = -1; first_valid = -1; first_en = -1;
        reads = 0; transfers = 0; last_addr = -1; drop_left = 0; dropped = 0;
        for (n = 1; n <= BUDGET; n++) begin
            start = 1'b0;
            if (done) begin
                done_at = n;
                checkOutput("busy_with_done", busy, 1);
                break;
            end
            checkOutput("busy_high", busy, 1);

            if (mode == 1)
                col_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (!dropped && col_valid && col_index == 9'd1) begin
                    dropped = 1;
                    drop_left = 3;
                end
                col_ready = (drop_left == 0);
                if (drop_left > 0) drop_left--;
            end else
                col_ready = 1'b1;

            if (mem_en) begin
                if (first_en < 0) first_en = n;
                reads++;
                last_addr = int'(mem_addr);
                if (addrq.size() > 0) checkOutput("fetch_addr", mem_addr, addrq.pop_front());
            end
            if (col_valid) begin
                if (first_valid < 0) first_valid = n;
                checkOutput("no_read_in_emit", mem_en, 0);
                obs = {a, b, c, col_index};
                if (tripq.size() > 0) begin
                    checkOutput("triplet", obs, tripq[0]);
                    if (col_ready) begin
                        if (col_index == 9'd0) first_abc = {a, b, c};
                        void'(tripq.pop_front());
                    end
                end
                if (col_ready) transfers++;
            end

            if (pulse_start && (n % 37 == 5))
                applyStimulus(1'b1, 9'($urandom_range(0, 287)));
            tick();
        end
        start = 1'b0;

        checkOutput("done_seen", done_at >= 0, 1);
        checkOutput("read_count", reads, exp_reads);
        checkOutput("transfer_count", transfers, exp_trans);
        if (!valid_row)
            checkOutput("reject_done_time", done_at, 1);
        else begin
            checkOutput("first_mem_en", first_en, 1);
            checkOutput("first_col_valid", first_valid, 5);
            checkOutput("last_addr", last_addr, (y + 1) * WPR + WPR - 1);
            if (mode == 0) checkOutput("done_time", done_at, 1 + 8 * WPR);
            if (mode == 2) checkOutput("done_time_bp", done_at, 4 + 8 * WPR);
        end
        tick();
        checkOutput("done_pulse_len", done, 0);
        checkOutput("busy_falls", busy, 0);
    endtask

    initial begin
        logic [9:0] alu_sum;
        int guard;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0]   = 32'h04030201;
        mem[88]  = 32'h14131211;
        mem[176] = 32'h24232221;
        mem[9 * WPR]  = {24'h00AB12, 8'd10};
        mem[10 * WPR] = {24'h00CD34, 8'd20};
        mem[11 * WPR] = {24'h00EF56, 8'd30};

        rst = 1'b1;
        repeat (3) tick();
        checkOutput("reset_outputs", {busy, done, mem_en, col_valid, mem_addr, a, b, c, col_index}, 0);
        rst = 1'b0;
        tick();

        runRow(1, 0, 0);
        runRow(1, 2, 0);
        runRow(143, 0, 0);
        runRow(0, 0, 0);
        runRow(287, 0, 0);
        runRow($urandom_range(1, 286), 1, 0);

        // Abort mid-emission, then restart a fresh row from word 0.
        applyStimulus(1'b1, 9'd5);
        col_ready = 1'b1;
        tick();
        applyStimulus(1'b0, 9'd5);
        guard = 0;
        while (!(col_valid && col_index == 9'd2) && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("reach_k2", col_index, 2);
        rst = 1'b1;
        tick();
        checkOutput("midrun_reset", {busy, done, mem_en, col_valid, mem_addr, a, b, c, col_index}, 0);
        rst = 1'b0;
        tick();
        runRow(5, 0, 1);

        runRow(10, 1, 0);
        alu_sum = 10'(first_abc[23:16]) + 10'(2 * first_abc[15:8]) + 10'(first_abc[7:0]);
        checkOutput("alu_sum", alu_sum, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
